cr16_controller: RTL and testbench
==================================

# cr16_controller

Multicycle control unit that sits directly upstream of the register-file/ALU datapath. It fetches 16-bit instructions over a ready/request instruction-memory port, holds them in an instruction register, and decodes them into the datapath control word. It also owns the program counter, evaluating conditional branches against the datapath's registered PSR.

## Interface
- WIDTH, 16, datapath and PC width
- REGBITS, 4, register-address width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  WIDTH  fetch address (= PC)
- imem_ready  in  1  fetch data valid this cycle
- imem_data  in  16  instruction word
- PSR  in  8  datapath flags: C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7
- regWrite, shiftOrALU, alusrca, alusrcb, shiftType  out  1 each  datapath controls
- aluControl  out  4  ALU operation
- regAddress1, regAddress2  out  REGBITS  Rdest/Rsrc
- immediate, shiftDirection  out  WIDTH  sign-extended operands
- illegal  out  1  one-cycle pulse on an undecodable instruction

## Operation
- Instruction fields:
  - IR[15:12] is the opcode.
  - IR[11:8] is Rdest, or cond for branches.
  - IR[7:4] is ext.
  - IR[3:0] is Rsrc, or the shift amount.
  - IR[7:0] is imm8 or the branch displacement.
- States: FETCH, DECODE, EXEC, BRANCH.
- FETCH:
  - imem_req=1 and imem_addr=PC.
  - On imem_ready=1, latch imem_data into IR and go to DECODE; otherwise stay.
  - imem_addr must stay stable while waiting.
- DECODE registers the control word, then selects the next state:
  - opcode 0000 (R-type):
    - aluControl=ext, regAddress1=Rdest, regAddress2=Rsrc.
    - alusrca=1, alusrcb=0, shiftOrALU=1.
    - Go to EXEC.
  - opcode 1000 (shift):
    - shiftOrALU=0, regAddress1=Rdest.
    - shiftDirection=sext(IR[3:0]); a negative value means shift right.
    - shiftType=IR[4] (0 logical, 1 arithmetic).
    - Go to EXEC.
  - opcodes 0001–0111 and 1001–1011 (immediate):
    - aluControl=opcode, immediate=sext(imm8).
    - alusrca=1, alusrcb=1, shiftOrALU=1.
    - Go to EXEC.
  - opcode 1100 (Bcond): go to BRANCH.
  - opcodes 1101–1111: pulse illegal, PC←PC+1, go to FETCH.
- EXEC:
  - regWrite=1 for exactly this cycle, except R-type with ext=1011 (CMP), which keeps regWrite=0.
  - PC←PC+1, then go to FETCH.
- BRANCH:
  - Evaluate cond against the current PSR.
  - Taken: PC←PC+sext(disp). Not taken: PC←PC+1.
  - Go to FETCH.
- Cond codes:
  - 0000 Z=1; 0001 Z=0
  - 0010 C=1; 0011 C=0
  - 0100 L=1; 0101 L=0
  - 0110 N=1; 0111 N=0
  - 1000 F=1; 1001 F=0
  - 1110 always; all others never.
- PC arithmetic is modulo 2^WIDTH; wrap-around is silent.
- Control outputs other than regWrite and illegal hold their last decoded value outside EXEC.

## Timing
- Reset (async assert, sync release):
  - PC=0, IR=0, state=FETCH.
  - All outputs are 0 except imem_req=1 in the first cycle after release.
- Zero-wait fetch: an instruction takes 3 cycles (FETCH, DECODE, EXEC or BRANCH). Each wait cycle adds one.
- Control outputs are valid in EXEC. The datapath writes Rdest and updates PSR on the clock edge that ends EXEC.
- A branch observes the PSR produced by the most recent EXEC. There are no intervening hazards.
- Reset asserted mid-EXEC forces regWrite=0 immediately (asynchronous), so no write occurs.
- imem_ready is ignored outside FETCH.

## Configuration
- CTRL_BRANCH_EN defined: Bcond is decoded as described, including the BRANCH state.
- Undefined:
  - The BRANCH state and the condition evaluator are removed.
  - opcode 1100 is treated as illegal: pulse illegal, PC←PC+1, no register write.

## Structure
- Shared package cr16_ctrl_pkg holds:
  - the state enum;
  - opcode constants (OP_RTYPE, OP_SHIFT, OP_BCOND) and EXT_CMP;
  - cond-code constants;
  - PSR bit-index constants.
- One combinational sub-module, cr16_cond_eval: inputs (cond[3:0], PSR[7:0]), output taken. It is instantiated only under CTRL_BRANCH_EN.

## Test plan
- Reset held low for 3 cycles, then released with imem_ready=1 and imem_data=0x0153 → imem_req=1 with imem_addr=0 on the first cycle.
- Instruction 0x0153 → in EXEC, regAddress1=1, regAddress2=3, aluControl=5, alusrca=1, alusrcb=0, shiftOrALU=1, regWrite high for one cycle; PC goes 0→1.
- Instruction 0x52FF → aluControl=5, immediate=0xFFFF, alusrcb=1.
- Instruction 0x01B2 (CMP) → regWrite stays 0.
- Instruction 0x8015 → shiftOrALU=0, shiftDirection=0x0005, shiftType=1.
- Fetch stall: imem_ready low for 4 cycles → imem_req=1, imem_addr unchanged, no control changes; the instruction completes 3 cycles after ready.
- Branch 0xC0FC at PC=10 → with Z=1 next fetch address is 6; with Z=0 it is 11. 0xCEFC is always taken (→6).
- Illegal instruction 0xD000 → illegal pulses for one cycle, no regWrite, PC+1. With CTRL_BRANCH_EN undefined, 0xC0FC behaves the same way.
- Reset asserted during EXEC → regWrite drops to 0 within the same cycle, and PC=0.

Source files
------------

// File: rtl/cr16_ctrl_pkg.sv
// Shared types and constants for the CR16 multicycle control unit:
// FSM states, instruction classes, opcode/cond encodings and PSR bit positions.
package cr16_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_BRANCH = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_SHIFT,
      CLS_IMM,
      CLS_BCOND,
      CLS_ILLEGAL
   } iclass_t;

   localparam logic [3:0] OP_RTYPE = 4'h0;
   localparam logic [3:0] OP_SHIFT = 4'h8;
   localparam logic [3:0] OP_BCOND = 4'hC;
   localparam logic [3:0] EXT_CMP  = 4'hB;

   localparam logic [3:0] COND_EQ = 4'h0;  // Z=1
   localparam logic [3:0] COND_NE = 4'h1;  // Z=0
   localparam logic [3:0] COND_CS = 4'h2;  // C=1
   localparam logic [3:0] COND_CC = 4'h3;  // C=0
   localparam logic [3:0] COND_LS = 4'h4;  // L=1
   localparam logic [3:0] COND_LC = 4'h5;  // L=0
   localparam logic [3:0] COND_MI = 4'h6;  // N=1
   localparam logic [3:0] COND_PL = 4'h7;  // N=0
   localparam logic [3:0] COND_FS = 4'h8;  // F=1
   localparam logic [3:0] COND_FC = 4'h9;  // F=0
   localparam logic [3:0] COND_UC = 4'hE;  // always

   localparam int unsigned PSR_C = 0;
   localparam int unsigned PSR_L = 2;
   localparam int unsigned PSR_F = 5;
   localparam int unsigned PSR_Z = 6;
   localparam int unsigned PSR_N = 7;

   function automatic iclass_t classify(input logic [3:0] op);
      if (op == OP_RTYPE)      return CLS_RTYPE;
      else if (op == OP_SHIFT) return CLS_SHIFT;
      else if (op == OP_BCOND) return CLS_BCOND;
      else if (op <= 4'hB)     return CLS_IMM;   // 0 and 8 already taken above
      else                     return CLS_ILLEGAL;
   endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// Branch condition evaluator: decides taken/not-taken from cond and PSR.
// Only exists when CTRL_BRANCH_EN is defined.
`ifdef CTRL_BRANCH_EN
module cr16_cond_eval
   import cr16_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [7:0] PSR,
   output logic       taken
);

   logic w_unused_psr;
   assign w_unused_psr = ^{PSR[4:3], PSR[1]};

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_EQ: taken =  PSR[PSR_Z];
         COND_NE: taken = ~PSR[PSR_Z];
         COND_CS: taken =  PSR[PSR_C];
         COND_CC: taken = ~PSR[PSR_C];
         COND_LS: taken =  PSR[PSR_L];
         COND_LC: taken = ~PSR[PSR_L];
         COND_MI: taken =  PSR[PSR_N];
         COND_PL: taken = ~PSR[PSR_N];
         COND_FS: taken =  PSR[PSR_F];
         COND_FC: taken = ~PSR[PSR_F];
         COND_UC: taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

endmodule
`endif

// File: rtl/cr16_controller.sv
// CR16 multicycle control unit: fetch / decode / execute FSM, PC and control word.
// Conditional branches are built only when CTRL_BRANCH_EN is defined.
module cr16_controller
   import cr16_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned REGBITS = 4
)(
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [WIDTH-1:0]   imem_addr,
   input  logic               imem_ready,
   input  logic [15:0]        imem_data,
   input  logic [7:0]         PSR,
   output logic               regWrite,
   output logic               shiftOrALU,
   output logic               alusrca,
   output logic               alusrcb,
   output logic               shiftType,
   output logic [3:0]         aluControl,
   output logic [REGBITS-1:0] regAddress1,
   output logic [REGBITS-1:0] regAddress2,
   output logic [WIDTH-1:0]   immediate,
   output logic [WIDTH-1:0]   shiftDirection,
   output logic               illegal
);

   state_t             r_state, w_state_next;
   logic [WIDTH-1:0]   r_pc, w_pc_next, w_pc_inc;
   logic [15:0]        r_ir;

   logic               r_soa, r_sa, r_sb, r_st, r_cmp;
   logic [3:0]         r_alu;
   logic [REGBITS-1:0] r_ra1, r_ra2;
   logic [WIDTH-1:0]   r_imm, r_sd;

   logic [3:0]         w_opcode, w_rdest, w_ext, w_rsrc;
   iclass_t            w_class;
   logic [WIDTH-1:0]   w_sext8, w_sext4;
   logic               w_illegal;

   assign w_opcode = r_ir[15:12];
   assign w_rdest  = r_ir[11:8];
   assign w_ext    = r_ir[7:4];
   assign w_rsrc   = r_ir[3:0];
   assign w_class  = classify(w_opcode);
   assign w_sext8  = {{(WIDTH-8){r_ir[7]}}, r_ir[7:0]};
   assign w_sext4  = {{(WIDTH-4){r_ir[3]}}, r_ir[3:0]};
   assign w_pc_inc = r_pc + WIDTH'(1);

`ifdef CTRL_BRANCH_EN
   logic w_taken;

   cr16_cond_eval u_cond_eval (
      .cond  (w_rdest),
      .PSR   (PSR),
      .taken (w_taken)
   );
`else
   logic w_unused_psr;
   assign w_unused_psr = ^PSR;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_FETCH;
         r_pc    <= '0;
         r_ir    <= '0;
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         if (r_state == ST_FETCH && imem_ready)
            r_ir <= imem_data;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      w_illegal    = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (imem_ready)
               w_state_next = ST_DECODE;
         end
         ST_DECODE: begin
            case (w_class)
               CLS_RTYPE, CLS_SHIFT, CLS_IMM: w_state_next = ST_EXEC;
`ifdef CTRL_BRANCH_EN
               CLS_BCOND: w_state_next = ST_BRANCH;
`endif
               default: begin
                  w_illegal    = 1'b1;
                  w_pc_next    = w_pc_inc;
                  w_state_next = ST_FETCH;
               end
            endcase
         end
         ST_EXEC: begin
            w_pc_next    = w_pc_inc;
            w_state_next = ST_FETCH;
         end
`ifdef CTRL_BRANCH_EN
         ST_BRANCH: begin
            w_pc_next    = w_taken ? (r_pc + w_sext8) : w_pc_inc;
            w_state_next = ST_FETCH;
         end
`endif
         default: w_state_next = ST_FETCH;
      endcase
   end

   // Each class loads only the fields it owns; everything else keeps its last decoded value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_soa <= 1'b0;
         r_sa  <= 1'b0;
         r_sb  <= 1'b0;
         r_st  <= 1'b0;
         r_cmp <= 1'b0;
         r_alu <= '0;
         r_ra1 <= '0;
         r_ra2 <= '0;
         r_imm <= '0;
         r_sd  <= '0;
      end else if (r_state == ST_DECODE) begin
         case (w_class)
            CLS_RTYPE: begin
               r_alu <= w_ext;
               r_ra1 <= REGBITS'(w_rdest);
               r_ra2 <= REGBITS'(w_rsrc);
               r_sa  <= 1'b1;
               r_sb  <= 1'b0;
               r_soa <= 1'b1;
               r_cmp <= (w_ext == EXT_CMP);
            end
            CLS_SHIFT: begin
               r_soa <= 1'b0;
               r_ra1 <= REGBITS'(w_rdest);
               r_sd  <= w_sext4;
               r_st  <= r_ir[4];
               r_cmp <= 1'b0;
            end
            CLS_IMM: begin
               r_alu <= w_opcode;
               r_ra1 <= REGBITS'(w_rdest);
               r_imm <= w_sext8;
               r_sa  <= 1'b1;
               r_sb  <= 1'b1;
               r_soa <= 1'b1;
               r_cmp <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // regWrite decodes straight from the state register so an async reset kills it at once.
   assign regWrite       = (r_state == ST_EXEC) && !r_cmp;
   assign illegal        = w_illegal;
   assign imem_req       = (r_state == ST_FETCH);
   assign imem_addr      = r_pc;
   assign shiftOrALU     = r_soa;
   assign alusrca        = r_sa;
   assign alusrcb        = r_sb;
   assign shiftType      = r_st;
   assign aluControl     = r_alu;
   assign regAddress1    = r_ra1;
   assign regAddress2    = r_ra2;
   assign immediate      = r_imm;
   assign shiftDirection = r_sd;

endmodule

// File: tb/tb_cr16_controller.sv
// Scoreboard bench for cr16_controller: driver queues expected fetch/result records,
// a negedge monitor checks them at every fetch handshake.
module tb_cr16_controller;

   localparam int unsigned WIDTH   = 16;
   localparam int unsigned REGBITS = 4;

   logic               clk = 1'b0;
   logic               reset;
   logic               imem_req;
   logic [WIDTH-1:0]   imem_addr;
   logic               imem_ready;
   logic [15:0]        imem_data;
   logic [7:0]         psr;
   logic               regWrite, shiftOrALU, alusrca, alusrcb, shiftType, illegal;
   logic [3:0]         aluControl;
   logic [REGBITS-1:0] regAddress1, regAddress2;
   logic [WIDTH-1:0]   immediate, shiftDirection;

   always #5 clk = ~clk;

   cr16_controller #(.WIDTH(WIDTH), .REGBITS(REGBITS)) dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_data      (imem_data),
      .PSR            (psr),
      .regWrite       (regWrite),
      .shiftOrALU     (shiftOrALU),
      .alusrca        (alusrca),
      .alusrcb        (alusrcb),
      .shiftType      (shiftType),
      .aluControl     (aluControl),
      .regAddress1    (regAddress1),
      .regAddress2    (regAddress2),
      .immediate      (immediate),
      .shiftDirection (shiftDirection),
      .illegal        (illegal)
   );

   typedef struct {
      logic [15:0] instr;
      int          stall;
      logic [7:0]  psr;
      logic [15:0] next_pc;
      logic        wr, ill;
      logic [3:0]  alu;
      logic        ra_care;
      logic [3:0]  ra1, ra2;
      logic        sa, sb, soa, st;
      logic [15:0] imm, sd;
   } vec_t;

   typedef struct {
      logic [15:0] addr;
      logic        has_prev;
      vec_t        prev;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   hs_cyc = 0;
   int   wr_cnt = 0;
   int   ill_cnt = 0;
   logic mon_en = 1'b0;
   exp_t me;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   function automatic vec_t mk(input logic [15:0] instr, input int stall, input logic [7:0] p,
                               input logic [15:0] npc, input logic wr, input logic ill,
                               input logic [3:0] alu, input logic rc, input logic [3:0] ra1,
                               input logic [3:0] ra2, input logic sa, input logic sb,
                               input logic soa, input logic st, input logic [15:0] imm,
                               input logic [15:0] sd);
      vec_t v;
      v.instr = instr; v.stall = stall; v.psr = p; v.next_pc = npc; v.wr = wr; v.ill = ill;
      v.alu = alu; v.ra_care = rc; v.ra1 = ra1; v.ra2 = ra2; v.sa = sa; v.sb = sb;
      v.soa = soa; v.st = st; v.imm = imm; v.sd = sd;
      return v;
   endfunction

   // Monitor: results of an instruction are judged at the handshake of the following fetch.
   always @(negedge clk) begin
      if (mon_en) begin
         if (regWrite === 1'b1) begin
            wr_cnt++;
            chk("wr_latency", cyc - hs_cyc, 2);
         end
         if (illegal === 1'b1) begin
            ill_cnt++;
            chk("ill_latency", cyc - hs_cyc, 1);
         end
         if (imem_req && !imem_ready && exp_q.size() > 0)
            chk("stall_addr", imem_addr, exp_q[0].addr);
         if (imem_req && imem_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_fetch: got addr 0x%0h, required no fetch", imem_addr);
            end else begin
               me = exp_q.pop_front();
               chk("fetch_addr", imem_addr, me.addr);
               if (me.has_prev) begin
                  chk("regWrite_pulses", wr_cnt, me.prev.wr);
                  chk("illegal_pulses", ill_cnt, me.prev.ill);
                  chk("aluControl", aluControl, me.prev.alu);
                  if (me.prev.ra_care) chk("regAddress1", regAddress1, me.prev.ra1);
                  chk("regAddress2", regAddress2, me.prev.ra2);
                  chk("alusrca", alusrca, me.prev.sa);
                  chk("alusrcb", alusrcb, me.prev.sb);
                  chk("shiftOrALU", shiftOrALU, me.prev.soa);
                  chk("shiftType", shiftType, me.prev.st);
                  chk("immediate", immediate, me.prev.imm);
                  chk("shiftDirection", shiftDirection, me.prev.sd);
               end
            end
            wr_cnt  = 0;
            ill_cnt = 0;
            hs_cyc  = cyc;
         end
      end
   end

   task automatic fetch(input logic [15:0] instr, input int stall, input logic [7:0] p, input exp_t e);
      int guard = 0;
      while (imem_req !== 1'b1 && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      if (imem_req !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL fetch_timeout: imem_req=%b, required 1", imem_req);
         return;
      end
      exp_q.push_back(e);
      psr = p;
      for (int s = 0; s < stall; s++) begin
         imem_ready = 1'b0;
         @(posedge clk); #1;
      end
      imem_ready = 1'b1;
      imem_data  = instr;
      @(posedge clk); #1;
      imem_ready = 1'b0;
      imem_data  = 16'hFFFF;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        rows[$];
      exp_t        e;
      logic [15:0] pc;

      reset      = 1'b0;
      imem_ready = 1'b1;
      imem_data  = 16'h0153;
      psr        = 8'h00;

      //                instr    st psr   npc      wr ill alu rc ra1   ra2   sa sb soa st imm       sd
      rows.push_back(mk(16'h0153, 0, 8'h00, 16'h0001, 1, 0, 4'h5, 1, 4'h1, 4'h3, 1, 0, 1, 0, 16'h0000, 16'h0000));
      rows.push_back(mk(16'h52FF, 0, 8'h00, 16'h0002, 1, 0, 4'h5, 0, 4'h2, 4'h3, 1, 1, 1, 0, 16'hFFFF, 16'h0000));
      rows.push_back(mk(16'h01B2, 0, 8'h00, 16'h0003, 0, 0, 4'hB, 1, 4'h1, 4'h2, 1, 0, 1, 0, 16'hFFFF, 16'h0000));
      rows.push_back(mk(16'h8015, 4, 8'h00, 16'h0004, 1, 0, 4'hB, 1, 4'h0, 4'h2, 1, 0, 0, 1, 16'hFFFF, 16'h0005));
      rows.push_back(mk(16'h830C, 0, 8'h00, 16'h0005, 1, 0, 4'hB, 1, 4'h3, 4'h2, 1, 0, 0, 0, 16'hFFFF, 16'hFFFC));
      rows.push_back(mk(16'hD000, 0, 8'h00, 16'h0006, 0, 1, 4'hB, 1, 4'h3, 4'h2, 1, 0, 0, 0, 16'hFFFF, 16'hFFFC));
      rows.push_back(mk(16'hB47F, 0, 8'h00, 16'h0007, 1, 0, 4'hB, 0, 4'h4, 4'h2, 1, 1, 1, 0, 16'h007F, 16'hFFFC));
      rows.push_back(mk(16'h0A0B, 0, 8'h00, 16'h0008, 1, 0, 4'h0, 1, 4'hA, 4'hB, 1, 0, 1, 0, 16'h007F, 16'hFFFC));
      rows.push_back(mk(16'h1080, 0, 8'h00, 16'h0009, 1, 0, 4'h1, 0, 4'h1, 4'hB, 1, 1, 1, 0, 16'hFF80, 16'hFFFC));
      rows.push_back(mk(16'h8F1F, 2, 8'h00, 16'h000A, 1, 0, 4'h1, 1, 4'hF, 4'hB, 1, 1, 0, 1, 16'hFF80, 16'hFFFF));
`ifdef CTRL_BRANCH_EN
      rows.push_back(mk(16'hC0FC, 0, 8'h40, 16'h0006, 0, 0, 4'h1, 1, 4'hF, 4'hB, 1, 1, 0, 1, 16'hFF80, 16'hFFFF));
      rows.push_back(mk(16'h0153, 0, 8'h00, 16'h0007, 1, 0, 4'h5, 1, 4'h1, 4'h3, 1, 0, 1, 1, 16'hFF80, 16'hFFFF));
      rows.push_back(mk(16'h8204, 0, 8'h00, 16'h0008, 1, 0, 4'h5, 1, 4'h2, 4'h3, 1, 0, 0, 0, 16'hFF80, 16'h0004));
      rows.push_back(mk(16'hC0FC, 0, 8'h00, 16'h0009, 0, 0, 4'h5, 1, 4'h2, 4'h3, 1, 0, 0, 0, 16'hFF80, 16'h0004));
      rows.push_back(mk(16'hC2FE, 0, 8'h01, 16'h0007, 0, 0, 4'h5, 1, 4'h2, 4'h3, 1, 0, 0, 0, 16'hFF80, 16'h0004));
      rows.push_back(mk(16'hC1FC, 0, 8'h00, 16'h0003, 0, 0, 4'h5, 1, 4'h2, 4'h3, 1, 0, 0, 0, 16'hFF80, 16'h0004));
      rows.push_back(mk(16'hCEFC, 0, 8'h40, 16'hFFFF, 0, 0, 4'h5, 1, 4'h2, 4'h3, 1, 0, 0, 0, 16'hFF80, 16'h0004));
      rows.push_back(mk(16'hC501, 0, 8'h04, 16'h0000, 0, 0, 4'h5, 1, 4'h2, 4'h3, 1, 0, 0, 0, 16'hFF80, 16'h0004));
      rows.push_back(mk(16'hCF10, 0, 8'hFF, 16'h0001, 0, 0, 4'h5, 1, 4'h2, 4'h3, 1, 0, 0, 0, 16'hFF80, 16'h0004));
      rows.push_back(mk(16'hC603, 0, 8'h80, 16'h0004, 0, 0, 4'h5, 1, 4'h2, 4'h3, 1, 0, 0, 0, 16'hFF80, 16'h0004));
      rows.push_back(mk(16'hC8F0, 0, 8'h00, 16'h0005, 0, 0, 4'h5, 1, 4'h2, 4'h3, 1, 0, 0, 0, 16'hFF80, 16'h0004));
`else
      rows.push_back(mk(16'hC0FC, 0, 8'h40, 16'h000B, 0, 1, 4'h1, 1, 4'hF, 4'hB, 1, 1, 0, 1, 16'hFF80, 16'hFFFF));
      rows.push_back(mk(16'hCEFC, 0, 8'h00, 16'h000C, 0, 1, 4'h1, 1, 4'hF, 4'hB, 1, 1, 0, 1, 16'hFF80, 16'hFFFF));
      rows.push_back(mk(16'hE000, 0, 8'h00, 16'h000D, 0, 1, 4'h1, 1, 4'hF, 4'hB, 1, 1, 0, 1, 16'hFF80, 16'hFFFF));
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_regWrite", regWrite, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_imem_addr", imem_addr, 0);
      chk("rst_aluControl", aluControl, 0);
      chk("rst_regAddress1", regAddress1, 0);
      chk("rst_immediate", immediate, 0);
      chk("rst_shiftDirection", shiftDirection, 0);
      chk("rst_shiftOrALU", shiftOrALU, 0);

      @(posedge clk); #1;
      reset  = 1'b1;
      mon_en = 1'b1;

      pc = 16'h0000;
      for (int i = 0; i < rows.size(); i++) begin
         e.addr     = pc;
         e.has_prev = (i != 0);
         e.prev     = (i != 0) ? rows[i-1] : rows[0];
         fetch(rows[i].instr, rows[i].stall, rows[i].psr, e);
         pc = rows[i].next_pc;
      end
      e.addr     = pc;
      e.has_prev = 1'b1;
      e.prev     = rows[rows.size()-1];
      fetch(16'h0153, 0, 8'h00, e);

      // Final instruction is now in DECODE; step into EXEC and reset mid-cycle.
      @(posedge clk); #1;
      chk("queue_drained", exp_q.size(), 0);
      chk("exec_regWrite", regWrite, 1);
      #2 reset = 1'b0;
      #1;
      chk("rst_in_exec_regWrite", regWrite, 0);
      chk("rst_in_exec_pc", imem_addr, 0);
      mon_en = 1'b0;
      repeat (2) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
